// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetches words over a single-outstanding req/ack port into a small
// circular fetch queue and presents the head to the decoder with valid/ready. Taken beq and
// j (evaluated when the head is consumed) flush the queue and redirect the fetch PC.
// Optional build macro FETCH_PERF_CNT_EN adds perf_fetch_cnt / perf_squash_cnt outputs.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_squash_cnt,
`endif
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  input  logic        nPC_sel,
  input  logic        zero,
  input  logic        jump
);

  localparam int unsigned PTR_W = $clog2(FQ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {StIdle, StReq, StSquash} state_e;

  state_e             state_q;
  logic [31:0]        q_inst [FQ_DEPTH];
  logic [31:0]        q_pc   [FQ_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;
  logic [31:0]        fetch_pc_q;
  logic [31:0]        fetch_pc_d;

  logic        consume;
  logic        take_jump;
  logic        redirect;
  logic        ack;
  logic        push;
  logic        space;
  logic [31:0] pc_plus4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] target;

  // Queue head is presented straight from storage; validity comes from the count.
  assign inst       = q_inst[rd_ptr_q];
  assign inst_pc    = q_pc[rd_ptr_q];
  assign opcode     = inst[31:26];
  assign funct      = inst[5:0];
  assign inst_valid = (count_q != '0);

  // Redirect decode, queue occupancy and next fetch PC.
  always_comb begin
    consume   = inst_valid & inst_ready;
    take_jump = consume & jump;
    redirect  = take_jump | (consume & nPC_sel & zero);
    pc_plus4  = inst_pc + 32'd4;
    br_target = pc_plus4 + {{14{inst[15]}}, inst[15:0], 2'b00};
    j_target  = {pc_plus4[31:28], inst[25:0], 2'b00};
    target    = take_jump ? j_target : br_target;
    ack       = imem_req & imem_ack;
    // Data acked in SQUASH or in a redirect cycle belongs to the wrong path.
    push      = ack & (state_q == StReq) & ~redirect;

    count_d = count_q;
    if (push) count_d = count_d + 1'b1;
    if (consume) count_d = count_d - 1'b1;
    if (redirect) count_d = '0;

    fetch_pc_d = fetch_pc_q;
    if (push) fetch_pc_d = fetch_pc_q + 32'd4;
    if (redirect) fetch_pc_d = target;

    // No request is outstanding after this edge, so only the queue needs room.
    space = (count_d < CNT_W'(FQ_DEPTH));
  end

  // Fetch FSM with registered request and address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      case (state_q)
        StIdle: begin
          imem_addr <= fetch_pc_d;
          if (space) begin
            state_q  <= StReq;
            imem_req <= 1'b1;
          end
        end
        StReq, StSquash: begin
          if (ack) begin
            imem_addr <= fetch_pc_d;
            if (space) begin
              state_q  <= StReq;
              imem_req <= 1'b1;
            end else begin
              state_q  <= StIdle;
              imem_req <= 1'b0;
            end
          end else if (redirect && state_q == StReq) begin
            // Keep req/addr stable; the stale response is dropped when it arrives.
            state_q <= StSquash;
          end
        end
        default: begin
          state_q  <= StIdle;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  // Circular fetch queue, occupancy count and fetch PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      fetch_pc_q <= RESET_PC;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        q_inst[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else begin
      if (push) begin
        q_inst[wr_ptr_q] <= imem_rdata;
        q_pc[wr_ptr_q]   <= imem_addr;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (redirect) begin
        rd_ptr_q <= wr_ptr_q;
      end else if (consume) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic        discard;
  logic [31:0] flushed;

  // Wrong-path work: dropped responses plus queue entries behind the redirecting head.
  always_comb begin
    discard = ack & ((state_q == StSquash) | redirect);
    flushed = redirect ? (32'(count_q) - 32'd1) : 32'd0;
  end

  // Free-running performance counters, wrapping on overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt  <= '0;
      perf_squash_cnt <= '0;
    end else begin
      perf_fetch_cnt  <= perf_fetch_cnt + 32'(push);
      perf_squash_cnt <= perf_squash_cnt + 32'(discard) + flushed;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: stimulus queues expected {pc, inst} heads, a monitor
// pops and compares on every consume. Memory model acks after a programmable wait.
module tb_instr_fetch_unit;

  localparam int unsigned FQ_DEPTH = 2;
  localparam logic [31:0] BEQ_WORD = 32'h1000_0003;
  localparam logic [31:0] J_WORD   = 32'h0800_0040;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        nPC_sel;
  logic        zero;
  logic        jump;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_squash_cnt;
`endif

  instr_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .FQ_DEPTH (FQ_DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_squash_cnt (perf_squash_cnt),
`endif
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .opcode          (opcode),
    .funct           (funct),
    .nPC_sel         (nPC_sel),
    .zero            (zero),
    .jump            (jump)
  );

  always #5 clk = ~clk;

  // Memory and decoder models
  int   ack_delay = 0;
  int   wait_cnt;
  logic beq_at8  = 1'b0;
  logic j_at10   = 1'b0;
  logic zero_cfg = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic b8, input logic j10);
    if (a == 32'h8 && b8) return BEQ_WORD;
    if (a == 32'h10 && j10) return J_WORD;
    return a;
  endfunction

  assign imem_ack   = imem_req && (wait_cnt >= ack_delay);
  assign imem_rdata = mem_word(imem_addr, beq_at8, j_at10);
  assign nPC_sel    = inst_valid && (opcode == 6'h04);
  assign jump       = inst_valid && (opcode == 6'h02);
  assign zero       = zero_cfg;

  always @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if (!imem_req || imem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  // Scoreboard
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   ack_cnt = 0;
  logic saw14 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_item(input logic [31:0] pc, input logic [31:0] ins);
    exp_t e;
    e.pc  = pc;
    e.ins = ins;
    exp_q.push_back(e);
  endtask

  // Monitor: each consume (valid & ready, sampled mid-cycle) pops one expected head.
  always @(negedge clk) begin
    if (!rst && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_head actual=%0h required=none", inst_pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("head_pc", inst_pc, mon_e.pc);
        check("head_inst", inst, mon_e.ins);
        check("head_opcode", {26'd0, opcode}, {26'd0, mon_e.ins[31:26]});
        check("head_funct", {26'd0, funct}, {26'd0, mon_e.ins[5:0]});
      end
    end
    if (imem_req && imem_ack) begin
      ack_cnt++;
      if (imem_addr == 32'h14) saw14 = 1'b1;
    end
  end

  task automatic reset_on();
    rst        = 1'b1;
    inst_ready = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_pc", inst_pc, 32'h0);
    check("rst_opcode", {26'd0, opcode}, 32'd0);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input string name, input int max, output int cycles);
    cycles = 0;
    while (exp_q.size() != 0 && cycles < max) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    inst_ready = 1'b0;
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_head(input logic [31:0] pc, input string name);
    bit found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(posedge clk);
      #1;
      if (inst_valid && inst_pc == pc) found = 1'b1;
    end
    check({name, "_found"}, {31'd0, found}, 32'd1);
  endtask

  initial begin
    int cyc;
    #1 rst = 1'b1;

    // 1: streaming, latency and throughput
    reset_on();
    ack_delay = 0; beq_at8 = 0; j_at10 = 0; zero_cfg = 0;
    for (int i = 0; i < 8; i++) expect_item(32'(i * 4), 32'(i * 4));
    inst_ready = 1'b1;
    release_rst();
    @(posedge clk);
    #1;
    check("t1_first_req", {31'd0, imem_req}, 32'd1);
    check("t1_first_addr", imem_addr, 32'h0);
    check("t1_valid_early", {31'd0, inst_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("t1_valid_lat", {31'd0, inst_valid}, 32'd1);
    drain("t1", 40, cyc);
    check("t1_cycles", 32'(cyc), 32'd8);

    // 2: back-pressure fills queue, then drain and resume
    reset_on();
    ack_delay = 0;
    ack_cnt   = 0;
    release_rst();
    repeat (10) @(posedge clk);
    #1;
    check("t2_pushes", 32'(ack_cnt), 32'(FQ_DEPTH));
    check("t2_req_low", {31'd0, imem_req}, 32'd0);
    check("t2_valid", {31'd0, inst_valid}, 32'd1);
    for (int i = 0; i < FQ_DEPTH + 4; i++) expect_item(32'(i * 4), 32'(i * 4));
    inst_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t2_resume_req", {31'd0, imem_req}, 32'd1);
    check("t2_resume_addr", imem_addr, 32'(4 * FQ_DEPTH));
    drain("t2", 40, cyc);

    // 3a: taken beq at 0x8 with simultaneous ack -> target 0x18
    reset_on();
    beq_at8 = 1; zero_cfg = 1;
    expect_item(32'h0, 32'h0);
    expect_item(32'h4, 32'h4);
    expect_item(32'h8, BEQ_WORD);
    expect_item(32'h18, 32'h18);
    expect_item(32'h1C, 32'h1C);
    expect_item(32'h20, 32'h20);
    inst_ready = 1'b1;
    release_rst();
    wait_head(32'h8, "t3a_head");
    @(posedge clk);
    #1;
    check("t3a_flush_valid", {31'd0, inst_valid}, 32'd0);
    check("t3a_target_req", {31'd0, imem_req}, 32'd1);
    check("t3a_target_addr", imem_addr, 32'h18);
    drain("t3a", 40, cyc);

    // 3b: not-taken beq falls through
    reset_on();
    beq_at8 = 1; zero_cfg = 0;
    expect_item(32'h0, 32'h0);
    expect_item(32'h4, 32'h4);
    expect_item(32'h8, BEQ_WORD);
    expect_item(32'hC, 32'hC);
    expect_item(32'h10, 32'h10);
    expect_item(32'h14, 32'h14);
    inst_ready = 1'b1;
    release_rst();
    drain("t3b", 40, cyc);

    // 4: jump with slow memory -> in-flight 0x14 is squashed, fetch resumes at 0x100
    reset_on();
    beq_at8 = 0; zero_cfg = 0; j_at10 = 1; ack_delay = 3;
    saw14 = 1'b0;
    expect_item(32'h0, 32'h0);
    expect_item(32'h4, 32'h4);
    expect_item(32'h8, 32'h8);
    expect_item(32'hC, 32'hC);
    expect_item(32'h10, J_WORD);
    expect_item(32'h100, 32'h100);
    expect_item(32'h104, 32'h104);
    inst_ready = 1'b1;
    release_rst();
    drain("t4", 120, cyc);
    check("t4_stale_acked", {31'd0, saw14}, 32'd1);
`ifdef FETCH_PERF_CNT_EN
    check("t4_squash_cnt_nz", {31'd0, (perf_squash_cnt != 0)}, 32'd1);
`endif

    // 5: reset while awaiting ack
    reset_on();
    j_at10 = 0; ack_delay = 4;
    release_rst();
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
        @(posedge clk);
        #1;
        if (inst_valid) seen = 1'b1;
      end
      check("t5_valid_seen", {31'd0, seen}, 32'd1);
    end
    check("t5_pending_req", {31'd0, imem_req}, 32'd1);
    check("t5_pending_addr", imem_addr, 32'h4);
    #2 rst = 1'b1;
    #1;
    check("t5_async_req", {31'd0, imem_req}, 32'd0);
    check("t5_async_valid", {31'd0, inst_valid}, 32'd0);
    ack_delay = 0;
    release_rst();
    @(posedge clk);
    #1;
    check("t5_restart_req", {31'd0, imem_req}, 32'd1);
    check("t5_restart_addr", imem_addr, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
